// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed display scan timer:
// index width, anode polarity and the smallest legal divide ratio.
package display_pkg;

  localparam int DIV_MIN = 2;

  function automatic int dig_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic an_off(input logic act_low);
    return act_low;
  endfunction

  function automatic logic an_on(input logic act_low);
    return ~act_low;
  endfunction

endpackage

// File: rtl/display_scan_timer_if.sv
// Control and display-drive bundle of the scan timer; master is the controller/bench,
// slave is the timer itself.
interface display_scan_timer_if
  import display_pkg::*;
#(
  parameter int CNT_W      = 18,
  parameter int NUM_DIGITS = 4
);
  localparam int DIG_W = dig_w(NUM_DIGITS);

  logic                  enable;
  logic                  div_load;
  logic [CNT_W-1:0]      div_value;
  logic                  y;
  logic                  tick;
  logic [DIG_W-1:0]      digit_sel;
  logic [NUM_DIGITS-1:0] anode;
  logic                  blank;

  modport master (
    output enable, div_load, div_value,
    input  y, tick, digit_sel, anode, blank
  );

  modport slave (
    input  enable, div_load, div_value,
    output y, tick, digit_sel, anode, blank
  );
endinterface

// File: rtl/display_scan_timer_digit_decoder.sv
// Digit index to one-hot anode drive; all anodes inactive while blanked.
module digit_decoder
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIG_W      = 2
) (
  input  logic [DIG_W-1:0]      idx,
  input  logic                  blank,
  input  logic                  act_low,
  output logic [NUM_DIGITS-1:0] an
);

  // One-hot decode with polarity applied per anode bit
  always_comb begin
    an = {NUM_DIGITS{an_off(act_low)}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!blank && (idx == DIG_W'(i))) begin
        an[i] = an_on(act_low);
      end else begin
        an[i] = an_off(act_low);
      end
    end
  end

endmodule

// File: rtl/display_scan_timer.sv
// Runtime-programmable refresh divider for an N-digit multiplexed 7-segment display:
// square wave, period tick, rotating digit select and blanked one-hot anode drive.
module display_scan_timer
  import display_pkg::*;
#(
  parameter int CNT_W       = 18,
  parameter int DIV_DEFAULT = 25000,
  parameter int NUM_DIGITS  = 4,
  parameter int BLANK_CYC   = 64,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic                clock_in,
  input  logic                reset,
  display_scan_timer_if.slave bus
);

  localparam int DIG_W = dig_w(NUM_DIGITS);
  localparam logic [CNT_W-1:0]      DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = {NUM_DIGITS{an_off(AN_ACT_LOW)}};

  logic [CNT_W-1:0]      z_q, z_d;
  logic [CNT_W-1:0]      div_a_q, div_a_d;
  logic [CNT_W-1:0]      div_sh_q, div_sh_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic                  y_q, y_d;
  logic                  tick_q, tick_d;
  logic                  blank_q, blank_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [NUM_DIGITS-1:0] anode_s;
  logic                  wrap_s;

  // Anode pattern follows the blank decision made in the same cycle
  digit_decoder #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIG_W      (DIG_W)
  ) u_dec (
    .idx     (digit_q),
    .blank   (blank_d),
    .act_low (AN_ACT_LOW),
    .an      (anode_s)
  );

  // Counter, divisor shadow/active pair, digit rotator and output decode
  always_comb begin
    z_d      = z_q;
    div_a_d  = div_a_q;
    div_sh_d = div_sh_q;
    digit_d  = digit_q;
    y_d      = y_q;
    tick_d   = 1'b0;
    blank_d  = blank_q;
    anode_d  = anode_q;
    // div_a is never below 2, so the minus one cannot underflow
    wrap_s   = (z_q >= (div_a_q - CNT_W'(1)));

    if (bus.div_load) begin
      div_sh_d = (bus.div_value < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : bus.div_value;
    end else begin
      div_sh_d = div_sh_q;
    end

    if (bus.enable) begin
      y_d     = (z_q < (div_a_q >> 1));
      tick_d  = wrap_s;
      blank_d = (int'(z_q) < BLANK_CYC);
      anode_d = anode_s;
      if (wrap_s) begin
        z_d     = '0;
        div_a_d = div_sh_q;
        digit_d = (digit_q == DIG_W'(NUM_DIGITS - 1)) ? DIG_W'(0) : digit_q + DIG_W'(1);
      end else begin
        z_d     = z_q + CNT_W'(1);
      end
    end else begin
      tick_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      z_q      <= '0;
      div_a_q  <= DIV_RST;
      div_sh_q <= DIV_RST;
      digit_q  <= '0;
      y_q      <= 1'b0;
      tick_q   <= 1'b0;
      blank_q  <= 1'b1;
      anode_q  <= AN_IDLE;
    end else begin
      z_q      <= z_d;
      div_a_q  <= div_a_d;
      div_sh_q <= div_sh_d;
      digit_q  <= digit_d;
      y_q      <= y_d;
      tick_q   <= tick_d;
      blank_q  <= blank_d;
      anode_q  <= anode_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.tick      = tick_q;
  assign bus.digit_sel = digit_q;
  assign bus.anode     = anode_q;
  assign bus.blank     = blank_q;

endmodule
